// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N weight-stationary systolic array: loads weight rows,
// streams activation vectors and tracks in-flight data until the array drains.
module systolic_ctrl #(
    parameter int unsigned N    = 4,
    parameter int unsigned MAXV = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          reload,
    input  logic [$clog2(MAXV+1)-1:0]     num_vec,
    output logic                          busy,
    output logic                          done,
    output logic                          w_rd,
    output logic [$clog2(N)-1:0]          w_addr,
    output logic [N-1:0]                  pe_load,
    input  logic                          a_valid,
    output logic                          a_ready,
    output logic [N-1:0]                  west_en,
    output logic [N-1:0]                  o_valid
);

    localparam int unsigned CW = $clog2(MAXV + 1);
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned LW = $clog2(N + 1);
    localparam int unsigned PW = 2 * N;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]    state_q,    state_d;
    logic [LW-1:0] load_cnt_q, load_cnt_d;
    logic [CW-1:0] vec_cnt_q,  vec_cnt_d;
    logic [CW-1:0] num_q,      num_d;
    logic [PW-1:1] pipe_q;
    logic          xfer;
    logic [PW-1:0] acc;

    // Counter guard keeps the accept count saturating at the latched job size.
    assign a_ready = !reset && (state_q == S_STREAM) && (vec_cnt_q < num_q);
    assign xfer    = a_valid & a_ready;

    // Entry j of acc is the accept flag delayed j cycles.
    assign acc     = {pipe_q, xfer};
    assign west_en = acc[N-1:0] & {N{~reset}};
    assign o_valid = acc[PW-1:N] & {N{~reset}};

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        vec_cnt_d  = vec_cnt_q;
        num_d      = num_q;
        busy       = 1'b0;
        done       = 1'b0;
        w_rd       = 1'b0;
        w_addr     = '0;
        pe_load    = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d      = num_vec;
                    vec_cnt_d  = '0;
                    load_cnt_d = '0;
                    if (reload)
                        state_d = S_LOAD;
                    else if (num_vec == '0)
                        state_d = S_DONE;
                    else
                        state_d = S_STREAM;
                end
            end
            S_LOAD: begin
                load_cnt_d = LW'(load_cnt_q + LW'(1));
                if (load_cnt_q == LW'(N))
                    state_d = (num_q == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                if (xfer) begin
                    vec_cnt_d = CW'(vec_cnt_q + CW'(1));
                    if (CW'(vec_cnt_q + CW'(1)) == num_q)
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (acc[PW-2:0] == '0)
                    state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs decode the registered state; all forced low while reset is held.
        if (!reset) begin
            busy = (state_q != S_IDLE);
            done = (state_q == S_DONE);
            if (state_q == S_LOAD) begin
                if (load_cnt_q < LW'(N)) begin
                    w_rd   = 1'b1;
                    w_addr = AW'(load_cnt_q);
                end
                for (int r = 0; r < N; r++)
                    pe_load[r] = (load_cnt_q == LW'(r + 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            load_cnt_q <= '0;
            vec_cnt_q  <= '0;
            num_q      <= '0;
            pipe_q     <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            vec_cnt_q  <= vec_cnt_d;
            num_q      <= num_d;
            pipe_q     <= acc[PW-2:0];
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Cycle-accurate check of systolic_ctrl against a job-level timeline model
// derived from transfer times, with random activation pacing and start noise.
module tb_systolic_ctrl;

    localparam int N     = 4;
    localparam int MAXV  = 255;
    localparam int CW    = $clog2(MAXV + 1);
    localparam int AW    = $clog2(N);
    localparam int BW    = 4 + AW + 3 * N;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          reload;
    logic [CW-1:0] num_vec;
    logic          busy, done, w_rd;
    logic [AW-1:0] w_addr;
    logic [N-1:0]  pe_load;
    logic          a_valid;
    logic          a_ready;
    logic [N-1:0]  west_en;
    logic [N-1:0]  o_valid;

    int n_checks = 0;
    int n_fail   = 0;

    bit av [DEPTH];
    bit xf [DEPTH];

    systolic_ctrl #(.N(N), .MAXV(MAXV)) dut (
        .clk(clk), .reset(reset), .start(start), .reload(reload),
        .num_vec(num_vec), .busy(busy), .done(done), .w_rd(w_rd),
        .w_addr(w_addr), .pe_load(pe_load), .a_valid(a_valid),
        .a_ready(a_ready), .west_en(west_en), .o_valid(o_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] observed();
        return {busy, done, w_rd, w_addr, pe_load, a_ready, west_en, o_valid};
    endfunction

    // One job from its start cycle (t=0); expected outputs come from the
    // job timeline: load window, stream window, transfer times, drain length.
    task automatic run_job(input string name, input bit rl, input int num,
                           input int av_mode, input int pct, input bit noise,
                           input int rst_at);
        int ss, last, dn, cnt, t_end;
        int ov_cnt [N];
        logic [BW-1:0] ex, ob;
        logic e_busy, e_done, e_wrd, e_ard;
        logic [AW-1:0] e_wa;
        logic [N-1:0] e_pl, e_we, e_ov;

        ss = rl ? N + 2 : 1;
        for (int t = 0; t < DEPTH; t++) begin
            case (av_mode)
                0:       av[t] = 1'b1;
                1:       av[t] = ($urandom_range(99) < pct) || (t >= 60);
                default: av[t] = (t == ss) || (t == ss + 4);
            endcase
            xf[t] = 1'b0;
        end
        cnt = 0;
        last = -1;
        for (int t = ss; t < DEPTH && cnt < num; t++) begin
            if (av[t]) begin
                xf[t] = 1'b1;
                cnt++;
                last = t;
            end
        end
        dn = (num == 0) ? ss : last + 2 * N;
        t_end = (rst_at >= 0) ? rst_at + 2 : dn;
        for (int c = 0; c < N; c++) ov_cnt[c] = 0;

        for (int t = 0; t <= t_end; t++) begin
            reset   = (t == rst_at);
            start   = (t == 0) ||
                      (noise && t >= 1 && t <= dn && (rst_at < 0 || t < rst_at) &&
                       ($urandom_range(1) == 1));
            reload  = (t == 0) ? rl : 1'($urandom_range(1));
            num_vec = (t == 0) ? CW'(num) : CW'($urandom_range(MAXV));
            a_valid = av[t];

            e_busy = (t >= 1 && t <= dn);
            e_done = (t == dn);
            e_wrd  = rl && t >= 1 && t <= N;
            e_wa   = e_wrd ? AW'(t - 1) : '0;
            e_pl   = '0;
            if (rl && t >= 2 && t <= N + 1) e_pl[t-2] = 1'b1;
            e_ard  = (num > 0) && t >= ss && t <= last;
            for (int r = 0; r < N; r++) begin
                e_we[r] = (t - r >= 0) && xf[t-r];
                e_ov[r] = (t - N - r >= 0) && xf[t-N-r];
            end
            ex = {e_busy, e_done, e_wrd, e_wa, e_pl, e_ard, e_we, e_ov};
            if (rst_at >= 0 && t >= rst_at) ex = '0;

            @(negedge clk);
            ob = observed();
            for (int c = 0; c < N; c++) if (o_valid[c]) ov_cnt[c]++;
            n_checks++;
            if (ob !== ex) begin
                n_fail++;
                $display("FAIL %s cycle %0d: outputs got %h expected %h", name, t, ob, ex);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        start = 1'b0;

        if (rst_at < 0) begin
            for (int c = 0; c < N; c++) begin
                n_checks++;
                if (ov_cnt[c] != num) begin
                    n_fail++;
                    $display("FAIL %s o_valid[%0d] pulse count: got %0d expected %0d",
                             name, c, ov_cnt[c], num);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        reload = 1'b1;
        num_vec = CW'(3);
        a_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (observed() !== '0) begin
            n_fail++;
            $display("FAIL reset_held: outputs got %h expected 0", observed());
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (observed() !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: outputs got %h expected 0", observed());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_job();
        run_job("load_job", 1'b1, 3, 0, 100, 1'b0, -1);
    endtask

    task automatic test_bubbles();
        run_job("bubbles", 1'b0, 2, 2, 0, 1'b0, -1);
    endtask

    task automatic test_zero_vec();
        run_job("zero_vec_load", 1'b1, 0, 1, 50, 1'b0, -1);
        run_job("zero_vec_reuse", 1'b0, 0, 1, 50, 1'b0, -1);
    endtask

    task automatic test_start_noise();
        run_job("start_noise", 1'b1, 4, 1, 40, 1'b1, -1);
        run_job("start_noise_reuse", 1'b0, 5, 1, 70, 1'b1, -1);
    endtask

    task automatic test_mid_reset();
        run_job("mid_reset", 1'b1, 5, 0, 100, 1'b0, N + 4);
        run_job("after_reset", 1'b0, 3, 1, 60, 1'b0, -1);
    endtask

    task automatic test_max_vec();
        run_job("max_vec", 1'b0, MAXV, 0, 100, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++)
            run_job("back_to_back", 1'($urandom_range(1)), $urandom_range(10), 1,
                    $urandom_range(20, 100), 1'($urandom_range(1)), -1);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        reload  = 1'b0;
        num_vec = '0;
        a_valid = 1'b0;
        test_reset();
        test_load_job();
        test_bubbles();
        test_zero_vec();
        test_start_noise();
        test_mid_reset();
        test_max_vec();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
